// File: rtl/adder_pipe_stage_pkg.sv
// Shared widths and result type for the registered adder feed/capture stage.
package adder_pipe_stage_pkg;

   localparam int W     = 32;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic         carry;
      logic [W-1:0] sum;
   } result_t;

   function automatic result_t make_result(input logic carry, input logic [W-1:0] sum);
      result_t r;
      r.carry = carry;
      r.sum   = sum;
      return r;
   endfunction

endpackage

// File: rtl/adder_pipe_stage_if.sv
// Operand/result handshakes plus the side-channel to the external ripple adder.
interface adder_pipe_stage_if
   import adder_pipe_stage_pkg::*;
#(
   parameter int W     = adder_pipe_stage_pkg::W,
   parameter int CNT_W = adder_pipe_stage_pkg::CNT_W
);

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [W-1:0]     add_in1;
   logic [W-1:0]     add_in2;
   logic [W-1:0]     add_sum;
   logic             add_carry;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_sum;
   logic             out_carry;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  in_valid, in_a, in_b, add_sum, add_carry, out_ready,
      output in_ready, add_in1, add_in2, out_valid, out_sum, out_carry, op_count
   );

   modport master (
      output in_valid, in_a, in_b, add_sum, add_carry, out_ready,
      input  in_ready, add_in1, add_in2, out_valid, out_sum, out_carry, op_count
   );

endinterface

// File: rtl/adder_pipe_stage_pipe_reg_slice.sv
// Generic single-entry valid/ready register slice; accepts while empty or draining.
module pipe_reg_slice #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic          load;

   assign in_ready  = !valid_q || out_ready;
   assign load      = in_valid && in_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   // Data holds when nothing loads so the consumer sees no needless toggling.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/adder_pipe_stage.sv
// Feed/capture register pair around an external combinational ripple adder,
// with a saturating count of results delivered downstream.
module adder_pipe_stage
   import adder_pipe_stage_pkg::*;
#(
   parameter int W     = adder_pipe_stage_pkg::W,
   parameter int CNT_W = adder_pipe_stage_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   adder_pipe_stage_if.slave bus
);

   logic             op_valid;
   logic             s1_ready;
   logic             s2_ready;
   logic [2*W-1:0]   op_data;
   logic             res_valid;
   logic [W:0]       res_data;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Stage 1: operand register, drives the adder for a full cycle
   pipe_reg_slice #(.DW(2*W)) u_stage1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (s1_ready),
      .in_data   ({bus.in_a, bus.in_b}),
      .out_valid (op_valid),
      .out_ready (s2_ready),
      .out_data  (op_data)
   );

   assign bus.in_ready = s1_ready;
   assign bus.add_in1  = op_data[2*W-1:W];
   assign bus.add_in2  = op_data[W-1:0];

   // Stage 2: result register capturing {carry, sum}
   pipe_reg_slice #(.DW(W+1)) u_stage2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (op_valid),
      .in_ready  (s2_ready),
      .in_data   ({bus.add_carry, bus.add_sum}),
      .out_valid (res_valid),
      .out_ready (bus.out_ready),
      .out_data  (res_data)
   );

   assign bus.out_valid = res_valid;
   assign bus.out_sum   = res_data[W-1:0];
   assign bus.out_carry = res_data[W];

   always_comb begin
      cnt_d = cnt_q;
      if (res_valid && bus.out_ready) cnt_d = sat_inc(cnt_q);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_adder_pipe_stage.sv
// Directed + random bench for adder_pipe_stage with an in-order reference queue.
module tb_adder_pipe_stage;
   import adder_pipe_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   adder_pipe_stage_if bus ();

   adder_pipe_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in for the external ripple adder
   assign {bus.add_carry, bus.add_sum} = {1'b0, bus.add_in1} + {1'b0, bus.add_in2};

   int          tests = 0;
   int          fails = 0;
   result_t     exp_q[$];
   int unsigned delivered = 0;
   logic [W:0]  held;

   function automatic logic [CNT_W-1:0] model_count();
      return (delivered > 32'hFFFF) ? 16'hFFFF : CNT_W'(delivered);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard step: sample handshakes before the edge, then advance one clock.
   task automatic tick();
      logic acc, del;
      result_t r;
      #1;
      acc = bus.in_valid && bus.in_ready;
      del = bus.out_valid && bus.out_ready;
      if (del) begin
         if (exp_q.size() == 0) begin
            chk("spurious_result", 64'(del), 64'd0);
         end else begin
            r = exp_q.pop_front();
            chk("result", 64'({bus.out_carry, bus.out_sum}), 64'(r));
            delivered++;
         end
      end
      if (acc) exp_q.push_back(result_t'({1'b0, bus.in_a} + {1'b0, bus.in_b}));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
   endtask

   task automatic drain();
      drive(1'b0, '0, '0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
      chk("op_count", 64'(bus.op_count), 64'(model_count()));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, '0);
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
      chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
      chk("rst_add_in1", 64'(bus.add_in1), 64'd0);
      chk("rst_add_in2", 64'(bus.add_in2), 64'd0);
      chk("rst_op_count", 64'(bus.op_count), 64'd0);

      // 1 + 2 with latency check
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0000_0001, 32'h0000_0002);
      tick();
      drive(1'b0, '0, '0);
      chk("lat_add_in1", 64'(bus.add_in1), 64'h1);
      chk("lat_add_in2", 64'(bus.add_in2), 64'h2);
      chk("lat_n_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("lat_n1_out_valid", 64'(bus.out_valid), 64'd1);
      chk("sum_1_2", 64'({bus.out_carry, bus.out_sum}), 64'h0_0000_0003);
      tick();
      chk("op_count_1", 64'(bus.op_count), 64'd1);

      // Carry corner cases
      drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
      tick();
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      drive(1'b0, '0, '0);
      chk("carry_wrap", 64'({bus.out_carry, bus.out_sum}), 64'h1_0000_0000);
      tick();
      chk("carry_max", 64'({bus.out_carry, bus.out_sum}), 64'h1_FFFF_FFFE);
      drain();

      // 100 back-to-back random pairs
      delivered = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, $urandom(), $urandom());
         tick();
         chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
      end
      drain();
      chk("op_count_100", 64'(bus.op_count), 64'd100);

      // Backpressure: both stages fill, outputs freeze
      bus.out_ready = 1'b0;
      drive(1'b1, $urandom(), $urandom());
      tick();
      drive(1'b1, $urandom(), $urandom());
      tick();
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      held = {bus.out_carry, bus.out_sum};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom(), $urandom());
         tick();
         chk("bp_hold", 64'({bus.out_carry, bus.out_sum}), 64'(held));
         chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      end
      drain();

      // Reset with both stages full
      bus.out_ready = 1'b0;
      drive(1'b1, $urandom(), $urandom());
      tick();
      drive(1'b1, $urandom(), $urandom());
      tick();
      drive(1'b0, '0, '0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      delivered = 0;
      chk("rstfull_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rstfull_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rstfull_op_count", 64'(bus.op_count), 64'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstfull_no_stale", 64'(bus.out_valid), 64'd0);
      end

      // Saturation: deliver 65534, then 3 more
      for (int i = 0; i < 65534; i++) begin
         drive(1'b1, $urandom(), $urandom());
         tick();
      end
      drain();
      chk("cnt_fffe", 64'(bus.op_count), 64'hFFFE);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom(), $urandom());
         tick();
      end
      drain();
      chk("cnt_sat", 64'(bus.op_count), 64'hFFFF);
      drive(1'b1, $urandom(), $urandom());
      tick();
      drain();
      chk("cnt_sat_hold", 64'(bus.op_count), 64'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
